// File: rtl/gprs_wb_arbiter.sv
// gprs_wb_arbiter: round-robin sharing of the register-file write port between
// NREQ write-back requesters, plus a per-register outstanding-write scoreboard
// used by decode for RAW-hazard stalls.

// Per-requester slice: zeroes its destination/data unless granted so the
// winner can be picked out with a plain OR across requesters.
module gprs_wb_lane #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic          gnt,
   input  logic [AW-1:0] ws_in,
   input  logic [DW-1:0] wd_in,
   output logic [AW-1:0] ws_g,
   output logic [DW-1:0] wd_g
);
   assign ws_g = gnt ? ws_in : '0;
   assign wd_g = gnt ? wd_in : '0;
endmodule

module gprs_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = 16,
   parameter int AW   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_ws,
   input  logic [NREQ*DW-1:0] req_wd,
   output logic [NREQ-1:0]    req_ready,
   input  logic               claim_valid,
   input  logic [AW-1:0]      claim_ws,
   output logic               we,
   output logic [AW-1:0]      ws,
   output logic [DW-1:0]      wd,
   output logic [(1<<AW)-1:0] busy,
   output logic               err
);
   localparam int NREG = 1 << AW;
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]               rr_ptr;
   logic [PW-1:0]               win;
   logic [NREQ-1:0]             gnt;
   logic                        xfer;
   logic [NREQ-1:0][AW-1:0]     ws_arr, ws_g_arr;
   logic [NREQ-1:0][DW-1:0]     wd_arr, wd_g_arr;
   logic [AW-1:0]               win_ws;
   logic [DW-1:0]               win_wd;
   logic [NREG-1:0]             busy_nxt;
   logic                        err_set;

   // unpack requester buses and build the granted-only slices
   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      assign ws_arr[i] = req_ws[i*AW +: AW];
      assign wd_arr[i] = req_wd[i*DW +: DW];
      gprs_wb_lane #(.DW(DW), .AW(AW)) u_lane (
         .gnt   (gnt[i]),
         .ws_in (ws_arr[i]),
         .wd_in (wd_arr[i]),
         .ws_g  (ws_g_arr[i]),
         .wd_g  (wd_g_arr[i])
      );
   end

   // first valid requester at or after rr_ptr (wrapping) wins; depends only on req_valid
   always_comb begin
      int  idx;
      logic found;
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            win      = PW'(idx);
         end
      end
   end

   // no grant may leak out while reset is held
   assign req_ready = reset ? gnt : '0;
   assign xfer      = |req_ready;

   // one-hot grant means OR-ing the masked slices yields the winner's fields
   always_comb begin
      win_ws = '0;
      win_wd = '0;
      for (int i = 0; i < NREQ; i++) begin
         win_ws = win_ws | ws_g_arr[i];
         win_wd = win_wd | wd_g_arr[i];
      end
   end

   // scoreboard update: the write clears, a claim sets, and set wins on collision
   always_comb begin
      busy_nxt = busy;
      if (xfer)        busy_nxt[win_ws]   = 1'b0;
      if (claim_valid) busy_nxt[claim_ws] = 1'b1;
   end

   // a second claim on a register whose write is still outstanding
   assign err_set = claim_valid && busy[claim_ws] && !(xfer && (win_ws == claim_ws));

   // round-robin pointer moves past the winner on every transfer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    rr_ptr <= '0;
      else if (xfer) rr_ptr <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
   end

   // single-stage write pipeline; ws/wd hold when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we <= 1'b0;
         ws <= '0;
         wd <= '0;
      end else begin
         we <= xfer;
         if (xfer) begin
            ws <= win_ws;
            wd <= win_wd;
         end
      end
   end

   // outstanding-write scoreboard and sticky protocol error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= '0;
         err  <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (err_set) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_gprs_wb_arbiter.sv
// Directed bench for gprs_wb_arbiter: expected writes go into a queue as
// stimulus is issued; a monitor pops and compares whenever we is high.
module tb_gprs_wb_arbiter;
   localparam int NREQ = 3;
   localparam int DW   = 16;
   localparam int AW   = 3;

   typedef struct {
      logic [AW-1:0] ws;
      logic [DW-1:0] wd;
   } wb_t;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_ws;
   logic [NREQ*DW-1:0] req_wd;
   logic [NREQ-1:0]    req_ready;
   logic               claim_valid;
   logic [AW-1:0]      claim_ws;
   logic               we;
   logic [AW-1:0]      ws;
   logic [DW-1:0]      wd;
   logic [7:0]         busy;
   logic               err;

   int  n_pass  = 0;
   int  n_total = 0;
   wb_t exp_q[$];

   gprs_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ws      (req_ws),
      .req_wd      (req_wd),
      .req_ready   (req_ready),
      .claim_valid (claim_valid),
      .claim_ws    (claim_ws),
      .we          (we),
      .ws          (ws),
      .wd          (wd),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wb_t e;
      e.ws = a;
      e.wd = d;
      exp_q.push_back(e);
   endtask

   // monitor: every register-file write must match the next expected one
   always @(negedge clk) begin
      if (reset === 1'b1 && we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", {29'd0, ws}, 32'hFFFF_FFFF);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_ws", {29'd0, ws}, {29'd0, e.ws});
            chk("wb_wd", {16'd0, wd}, {16'd0, e.wd});
         end
      end
   end

   initial begin
      reset       = 1'b0;
      req_valid   = 3'b111;
      req_ws      = '0;
      req_wd      = '0;
      claim_valid = 1'b0;
      claim_ws    = '0;
      #3;
      // reset state
      chk("rst_we",    {31'd0, we}, 32'd0);
      chk("rst_ws",    {29'd0, ws}, 32'd0);
      chk("rst_wd",    {16'd0, wd}, 32'd0);
      chk("rst_busy",  {24'd0, busy}, 32'd0);
      chk("rst_err",   {31'd0, err}, 32'd0);
      chk("rst_ready", {29'd0, req_ready}, 32'd0);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b1;
      step();

      // single request from requester 1
      req_valid = 3'b010;
      req_ws[1*AW +: AW] = 3'd5;
      req_wd[1*DW +: DW] = 16'hBEEF;
      push(3'd5, 16'hBEEF);
      @(negedge clk);
      chk("single_ready", {29'd0, req_ready}, 32'b010);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("single_we1", {31'd0, we}, 32'd1);
      step();
      @(negedge clk);
      chk("single_we0", {31'd0, we}, 32'd0);

      // scoreboard claim r3, requester 2 writes r3 in cycle 4 (rr_ptr is 2 here)
      claim_valid = 1'b1;
      claim_ws    = 3'd3;
      step();
      claim_valid = 1'b0;
      @(negedge clk);
      chk("sb_busy3_set", {31'd0, busy[3]}, 32'd1);
      step();
      step();
      req_valid = 3'b100;
      req_ws[2*AW +: AW] = 3'd3;
      req_wd[2*DW +: DW] = 16'h1234;
      push(3'd3, 16'h1234);
      @(negedge clk);
      chk("sb_ready2", {29'd0, req_ready}, 32'b100);
      chk("sb_busy3_hold", {31'd0, busy[3]}, 32'd1);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("sb_busy3_clr", {31'd0, busy[3]}, 32'd0);
      chk("sb_we", {31'd0, we}, 32'd1);

      // claim r6, then claim r6 again while requester 0 writes r6: set wins, no error
      step();
      claim_valid = 1'b1;
      claim_ws    = 3'd6;
      step();
      req_valid = 3'b001;
      req_ws[0*AW +: AW] = 3'd6;
      req_wd[0*DW +: DW] = 16'h6666;
      push(3'd6, 16'h6666);
      @(negedge clk);
      chk("cc_ready0", {29'd0, req_ready}, 32'b001);
      step();
      claim_valid = 1'b0;
      req_valid   = '0;
      @(negedge clk);
      chk("cc_busy6", {31'd0, busy[6]}, 32'd1);
      chk("cc_err", {31'd0, err}, 32'd0);

      // double claim r2 without a write
      step();
      claim_valid = 1'b1;
      claim_ws    = 3'd2;
      step();
      claim_valid = 1'b0;
      @(negedge clk);
      chk("dc_busy2", {31'd0, busy[2]}, 32'd1);
      step();
      claim_valid = 1'b1;
      claim_ws    = 3'd2;
      @(negedge clk);
      chk("dc_err_pre", {31'd0, err}, 32'd0);
      step();
      claim_valid = 1'b0;
      @(negedge clk);
      chk("dc_err_set", {31'd0, err}, 32'd1);
      for (int i = 0; i < 10; i++) step();
      @(negedge clk);
      chk("dc_err_sticky", {31'd0, err}, 32'd1);

      // async reset mid-transfer with all requesters valid (rr_ptr is 1 here)
      step();
      req_valid = 3'b111;
      req_ws = {3'd4, 3'd2, 3'd1};
      req_wd = {16'hA2A2, 16'hA1A1, 16'hA0A0};
      @(negedge clk);
      chk("ar_ready_pre", {29'd0, req_ready}, 32'b010);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_we",    {31'd0, we}, 32'd0);
      chk("ar_busy",  {24'd0, busy}, 32'd0);
      chk("ar_err",   {31'd0, err}, 32'd0);
      chk("ar_ready", {29'd0, req_ready}, 32'd0);
      #1;
      reset = 1'b1;

      // round-robin 0,1,2 after release, each drops valid after its transfer
      push(3'd1, 16'hA0A0);
      @(negedge clk);
      chk("rr_g0", {29'd0, req_ready}, 32'b001);
      chk("rr_we_idle", {31'd0, we}, 32'd0);
      step();
      req_valid = 3'b110;
      push(3'd2, 16'hA1A1);
      @(negedge clk);
      chk("rr_g1", {29'd0, req_ready}, 32'b010);
      chk("rr_we_a", {31'd0, we}, 32'd1);
      step();
      req_valid = 3'b100;
      push(3'd4, 16'hA2A2);
      @(negedge clk);
      chk("rr_g2", {29'd0, req_ready}, 32'b100);
      chk("rr_we_b", {31'd0, we}, 32'd1);
      step();
      req_valid = 3'b000;
      @(negedge clk);
      chk("rr_none", {29'd0, req_ready}, 32'd0);
      chk("rr_we_c", {31'd0, we}, 32'd1);
      step();
      // pointer back at 0: with 0 and 2 valid, 0 must win
      req_valid = 3'b101;
      push(3'd1, 16'hA0A0);
      @(negedge clk);
      chk("rr_wrap", {29'd0, req_ready}, 32'b001);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("rr_wrap_we", {31'd0, we}, 32'd1);
      step();
      @(negedge clk);
      chk("nb_busy", {24'd0, busy}, 32'd0);
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
